// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types and direction helpers for the obstacle motion generator.
package obstacle_pkg;
    typedef enum logic [1:0] {DIR_NEG_X = 2'b00, DIR_POS_X = 2'b01, DIR_NEG_Y = 2'b10, DIR_POS_Y = 2'b11} dir_t;
    typedef enum logic [1:0] {MODE_HORIZ = 2'b00, MODE_VERT = 2'b01, MODE_BOX_CW = 2'b10, MODE_BOX_CCW = 2'b11} mode_t;
    typedef enum logic {ST_MOVE = 1'b0, ST_DWELL = 1'b1} state_t;

    function automatic dir_t cw_next(input dir_t d);
        return d == DIR_POS_X ? DIR_POS_Y : d == DIR_POS_Y ? DIR_NEG_X : d == DIR_NEG_X ? DIR_NEG_Y : DIR_POS_X;
    endfunction

    function automatic dir_t ccw_next(input dir_t d);
        return d == DIR_POS_X ? DIR_NEG_Y : d == DIR_NEG_Y ? DIR_NEG_X : d == DIR_NEG_X ? DIR_POS_Y : DIR_POS_X;
    endfunction

    // Bounce modes pin the travel axis and keep only the sign from init; box modes keep cur.
    function automatic dir_t axis_dir(input mode_t m, input dir_t init, input dir_t cur);
        return m == MODE_HORIZ ? dir_t'({1'b0, init[0]}) : m == MODE_VERT ? dir_t'({1'b1, init[0]}) : cur;
    endfunction
endpackage

// File: rtl/obstacle_hit_detect.sv
// obstacle_hit_detect: box overlap test between obstacle centre and player centre.
module obstacle_hit_detect #(
    parameter int COORD_W = 10,
    parameter int SIZE    = 3
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_s,
    output logic               hit
);
    localparam logic [COORD_W:0] SZ = (COORD_W+1)'(SIZE);
    logic [COORD_W-1:0] dx, dy;
    logic [COORD_W:0]   reach;
    always_comb begin
        dx    = a_x >= b_x ? a_x - b_x : b_x - a_x;
        dy    = a_y >= b_y ? a_y - b_y : b_y - a_y;
        reach = {1'b0, b_s} + SZ;
        hit   = ({1'b0, dx} <= reach) && ({1'b0, dy} <= reach);
    end
endmodule

// File: rtl/obstacle_mover.sv
// obstacle_mover: per-frame bounce/box-patrol motion for one obstacle with clamping, dwell and turn strobe.
// Optional OBSTACLE_HIT_DETECT_EN enables the registered player collision flag.
module obstacle_mover
    import obstacle_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int STEP_W  = 4,
    parameter int DWELL_W = 6,
    parameter int SIZE    = 3
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               Enable,
    input  logic               Load,
    input  logic [1:0]         Mode,
    input  logic [1:0]         Dir_Init,
    input  logic [STEP_W-1:0]  Step,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic [COORD_W-1:0] Start_X,
    input  logic [COORD_W-1:0] Start_Y,
    input  logic [COORD_W-1:0] X_Min,
    input  logic [COORD_W-1:0] X_Max,
    input  logic [COORD_W-1:0] Y_Min,
    input  logic [COORD_W-1:0] Y_Max,
    input  logic [COORD_W-1:0] Player_X,
    input  logic [COORD_W-1:0] Player_Y,
    input  logic [COORD_W-1:0] Player_S,
    output logic [COORD_W-1:0] Pos_X,
    output logic [COORD_W-1:0] Pos_Y,
    output logic [COORD_W-1:0] Size,
    output logic [1:0]         Dir,
    output logic               Moving,
    output logic               Turn,
    output logic               Hit
);
    localparam int W = COORD_W + 2;
    typedef logic signed [W-1:0] s_t;
    localparam s_t SZ   = s_t'(SIZE);
    localparam s_t MAXC = s_t'((1 << COORD_W) - 1);

    function automatic logic [COORD_W-1:0] lim(input s_t v);
        return v < 0 ? '0 : v > MAXC ? '1 : v[COORD_W-1:0];
    endfunction

    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    dir_t               dir_q, dir_d, init_dir, turn_dir;
    mode_t              mode_q, mode_d;
    state_t             state_q, state_d;
    logic               turn_q, turn_d, hit_q, hit_d, hit_c, at_lim;
    logic [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y, cur, lo, hi, nxt;
    s_t                 stp, fwd, bwd;

`ifdef OBSTACLE_HIT_DETECT_EN
    obstacle_hit_detect #(.COORD_W(COORD_W), .SIZE(SIZE)) u_hit (
        .a_x(pos_x_q), .a_y(pos_y_q), .b_x(Player_X), .b_y(Player_Y), .b_s(Player_S), .hit(hit_c)
    );
`else
    logic unused_player;
    assign unused_player = ^{Player_X, Player_Y, Player_S};
    assign hit_c = 1'b0;
`endif

    // Centre limits are evaluated wide and saturated so narrow bounds never wrap.
    assign lo_x     = lim($signed({2'b00, X_Min}) + SZ);
    assign hi_x     = lim($signed({2'b00, X_Max}) - SZ);
    assign lo_y     = lim($signed({2'b00, Y_Min}) + SZ);
    assign hi_y     = lim($signed({2'b00, Y_Max}) - SZ);
    assign init_dir = axis_dir(mode_t'(Mode), dir_t'(Dir_Init), dir_t'(Dir_Init));

    always_comb begin
        cur      = dir_q[1] ? pos_y_q : pos_x_q;
        lo       = dir_q[1] ? lo_y : lo_x;
        hi       = dir_q[1] ? hi_y : hi_x;
        stp      = $signed({{(W-STEP_W){1'b0}}, Step});
        fwd      = $signed({2'b00, cur}) + stp;
        bwd      = $signed({2'b00, cur}) - stp;
        at_lim   = dir_q[0] ? (fwd >= $signed({2'b00, hi})) : (bwd <= $signed({2'b00, lo}));
        nxt      = at_lim ? (dir_q[0] ? hi : lo) : (dir_q[0] ? fwd[COORD_W-1:0] : bwd[COORD_W-1:0]);
        turn_dir = mode_q == MODE_BOX_CW ? cw_next(dir_q) : mode_q == MODE_BOX_CCW ? ccw_next(dir_q) :
                   dir_t'({dir_q[1], ~dir_q[0]});
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        turn_d   = 1'b0;
        if (Load) begin
            pos_x_d = Start_X;
            pos_y_d = Start_Y;
            dir_d   = init_dir;
            mode_d  = mode_t'(Mode);
            state_d = ST_MOVE;
            cnt_d   = '0;
            hit_d   = 1'b0;
        end else if (Enable) begin
            hit_d = hit_c;
            if (mode_t'(Mode) != mode_q) begin
                mode_d = mode_t'(Mode);
                dir_d  = axis_dir(mode_t'(Mode), dir_t'(Dir_Init), dir_q);
            end else if (state_q == ST_DWELL && cnt_q != DWELL_W'(1)) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else begin
                state_d = ST_MOVE;
                cnt_d   = '0;
                if (Step != '0) begin
                    if (dir_q[1]) pos_y_d = nxt;
                    else pos_x_d = nxt;
                    if (at_lim) begin
                        turn_d  = 1'b1;
                        dir_d   = turn_dir;
                        state_d = Dwell != '0 ? ST_DWELL : ST_MOVE;
                        cnt_d   = Dwell;
                    end
                end
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            pos_x_q <= Start_X;
            pos_y_q <= Start_Y;
            dir_q   <= init_dir;
            mode_q  <= mode_t'(Mode);
            state_q <= ST_MOVE;
            cnt_q   <= '0;
            turn_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            turn_q  <= turn_d;
            hit_q   <= hit_d;
        end
    end

    assign Pos_X  = pos_x_q;
    assign Pos_Y  = pos_y_q;
    assign Size   = COORD_W'(SIZE);
    assign Dir    = dir_q;
    assign Moving = state_q == ST_MOVE;
    assign Turn   = turn_q;
    assign Hit    = hit_q;
endmodule

// File: tb/tb_obstacle_mover.sv
// tb_obstacle_mover: directed checks of bounce, dwell, box patrol, reset/load/enable, step 0 and hit flag.
module tb_obstacle_mover;
    logic       frame_clk = 1'b0;
    logic       Reset_n, Enable, Load;
    logic [1:0] Mode, Dir_Init, Dir;
    logic [3:0] Step;
    logic [5:0] Dwell;
    logic [9:0] Start_X, Start_Y, X_Min, X_Max, Y_Min, Y_Max, Player_X, Player_Y, Player_S;
    logic [9:0] Pos_X, Pos_Y, Size;
    logic       Moving, Turn, Hit;
    int         n_chk = 0;
    int         n_fail = 0;
    int         turns;
`ifdef OBSTACLE_HIT_DETECT_EN
    localparam logic HIT_EXP = 1'b1;
`else
    localparam logic HIT_EXP = 1'b0;
`endif

    obstacle_mover dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .Enable(Enable), .Load(Load), .Mode(Mode),
        .Dir_Init(Dir_Init), .Step(Step), .Dwell(Dwell), .Start_X(Start_X), .Start_Y(Start_Y),
        .X_Min(X_Min), .X_Max(X_Max), .Y_Min(Y_Min), .Y_Max(Y_Max), .Player_X(Player_X),
        .Player_Y(Player_Y), .Player_S(Player_S), .Pos_X(Pos_X), .Pos_Y(Pos_Y), .Size(Size),
        .Dir(Dir), .Moving(Moving), .Turn(Turn), .Hit(Hit)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic load_at(input logic [9:0] x, input logic [9:0] y);
        Start_X = x;
        Start_Y = y;
        Load    = 1'b1;
        tick();
        Load    = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Enable = 1'b1; Load = 1'b0; Mode = 2'b00; Dir_Init = 2'b01;
        Step = 4'd4; Dwell = 6'd0; Start_X = 10'd190; Start_Y = 10'd70;
        X_Min = 10'd100; X_Max = 10'd200; Y_Min = 10'd50; Y_Max = 10'd90;
        Player_X = 10'd0; Player_Y = 10'd0; Player_S = 10'd2;
        tick();
        chk("rst_x", Pos_X, 190); chk("rst_y", Pos_Y, 70); chk("rst_dir", Dir, 1);
        chk("rst_moving", Moving, 1); chk("rst_turn", Turn, 0); chk("rst_hit", Hit, 0); chk("size", Size, 3);
        Reset_n = 1'b1;
        tick(); chk("hb_x1", Pos_X, 194);
        tick(); chk("hb_x2", Pos_X, 197); chk("hb_turn", Turn, 1); chk("hb_dir", Dir, 0);
        tick(); chk("hb_x3", Pos_X, 193); chk("hb_turn_off", Turn, 0);
        tick(); chk("hb_x4", Pos_X, 189);

        Dwell = 6'd2;
        load_at(10'd190, 10'd70); chk("dw_load", Pos_X, 190);
        tick(); chk("dw_x1", Pos_X, 194);
        tick(); chk("dw_x2", Pos_X, 197); chk("dw_mov2", Moving, 0); chk("dw_turn", Turn, 1);
        tick(); chk("dw_x3", Pos_X, 197); chk("dw_mov3", Moving, 0);
        tick(); chk("dw_x4", Pos_X, 193); chk("dw_mov4", Moving, 1);

        load_at(10'd190, 10'd70);
        tick(); tick(); chk("rd_dwell", Moving, 0);
        Reset_n = 1'b0;
        tick(); chk("rd_x", Pos_X, 190); chk("rd_mov", Moving, 1); chk("rd_turn", Turn, 0); chk("rd_dir", Dir, 1);
        Reset_n = 1'b1;
        tick(); tick(); chk("ld_dwell", Moving, 0);
        load_at(10'd190, 10'd70); chk("ld_x", Pos_X, 190); chk("ld_mov", Moving, 1); chk("ld_turn", Turn, 0);

        Dwell = 6'd0;
        tick(); tick(); chk("en_pre_turn", Turn, 1);
        Enable = 1'b0;
        tick(); chk("en_turn_off", Turn, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("en_x", Pos_X, 197); chk("en_dir", Dir, 0);
        Enable = 1'b1;
        tick(); chk("en_resume", Pos_X, 193);

        Step = 4'd0;
        load_at(10'd197, 10'd70);
        for (int i = 0; i < 6; i++) begin
            tick(); chk("s0_x", Pos_X, 197); chk("s0_turn", Turn, 0);
        end

        Step = 4'd4;
        load_at(10'd199, 10'd70);
        tick(); chk("clamp_x", Pos_X, 197); chk("clamp_turn", Turn, 1);

        Mode = 2'b01; Dir_Init = 2'b00;
        load_at(10'd150, 10'd60); chk("vb_dir", Dir, 2);
        tick(); chk("vb_y1", Pos_Y, 56); chk("vb_xfix", Pos_X, 150);
        tick(); chk("vb_y2", Pos_Y, 53); chk("vb_dir2", Dir, 3); chk("vb_turn", Turn, 1);

        Mode = 2'b10; Dir_Init = 2'b01; Step = 4'd2; X_Max = 10'd140;
        load_at(10'd103, 10'd53);
        turns = 0;
        for (int f = 1; f <= 68; f++) begin
            tick();
            if (Turn) turns++;
            if (f == 17) begin chk("cw1_x", Pos_X, 137); chk("cw1_y", Pos_Y, 53); chk("cw1_dir", Dir, 3); end
            if (f == 34) begin chk("cw2_x", Pos_X, 137); chk("cw2_y", Pos_Y, 87); chk("cw2_dir", Dir, 0); end
            if (f == 51) begin chk("cw3_x", Pos_X, 103); chk("cw3_y", Pos_Y, 87); chk("cw3_dir", Dir, 2); end
        end
        chk("cw4_x", Pos_X, 103); chk("cw4_y", Pos_Y, 53); chk("cw4_dir", Dir, 1); chk("cw4_turn", Turn, 1);
        chk("cw_turns", turns, 4);

        Mode = 2'b11;
        load_at(10'd103, 10'd53);
        for (int f = 0; f < 17; f++) tick();
        chk("ccw1_x", Pos_X, 137); chk("ccw1_dir", Dir, 2);
        tick(); chk("ccw2_y", Pos_Y, 53); chk("ccw2_turn", Turn, 1); chk("ccw2_dir", Dir, 0);

        Mode = 2'b00; Step = 4'd0; X_Max = 10'd200;
        Player_X = 10'd155; Player_Y = 10'd70; Player_S = 10'd2;
        load_at(10'd150, 10'd70); chk("hit_load", Hit, 0);
        tick(); chk("hit_155", Hit, HIT_EXP);
        Player_X = 10'd156;
        tick(); chk("hit_156", Hit, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
